// File: rtl/debouncer_pkg.sv
// Shared constants and helpers for the debouncer family (single-channel and bank).
// Counter widths are derived here so every user sizes its counters the same way.
package debouncer_pkg;

   localparam int DEF_N      = 4;
   localparam int DEF_DELAY  = 50000;
   localparam int DEF_HOLD   = 25000000;
   localparam int DEF_REPEAT = 5000000;

   typedef struct packed {
      logic z;
      logic rise;
      logic fall;
      logic long;
   } ch_evt_t;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/debouncer_channel.sv
// One debouncer channel: 2-FF synchroniser, stability filter, edge and long-press pulses.
// Long-press auto-repeat is compiled in when DEBOUNCER_BANK_REPEAT_EN is defined.
module debouncer_channel
   import debouncer_pkg::*;
#(
   parameter int DELAY  = DEF_DELAY,
   parameter int HOLD   = DEF_HOLD,
   parameter int REPEAT = DEF_REPEAT
) (
   input  logic    i_ck,
   input  logic    i_reset_n,
   input  logic    i_x,
   output ch_evt_t o_evt
);

   localparam int CW = cnt_width(DELAY);
`ifdef DEBOUNCER_BANK_REPEAT_EN
   localparam int HW = cnt_width(HOLD + REPEAT);
   localparam logic [HW-1:0] C_H_WRAP = HW'(HOLD + REPEAT - 1);
`else
   // REPEAT has no effect in this build; the hold counter stops at HOLD.
   localparam int HW = cnt_width(HOLD + 0 * REPEAT);
`endif
   localparam logic [CW-1:0] C_CNT_LAST = CW'(DELAY - 1);
   localparam logic [HW-1:0] C_H_HOLD   = HW'(HOLD);

   logic          r_sync;
   logic          r_xs;
   logic          r_s;
   logic [CW-1:0] r_cnt;
   logic [HW-1:0] r_h;
   logic          r_rise;
   logic          r_fall;
   logic          r_long;

   logic          w_s_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_rise_nxt;
   logic          w_fall_nxt;
   logic [HW-1:0] w_h_inc;
   logic [HW-1:0] w_h_nxt;
   logic          w_long_nxt;

   // Stability filter: accept xs only after DELAY consecutive differing cycles.
   always_comb begin
      w_s_nxt   = r_s;
      w_cnt_nxt = '0;
      if (r_xs == r_s) begin
         w_cnt_nxt = '0;
      end else if (r_cnt == C_CNT_LAST) begin
         w_s_nxt   = r_xs;
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_cnt + CW'(1);
      end
      w_rise_nxt = w_s_nxt & ~r_s;
      w_fall_nxt = ~w_s_nxt & r_s;
   end

   // Hold counter: restarts on press, pulses long when it reaches HOLD.
   always_comb begin
      w_h_inc    = r_h + HW'(1);
      w_h_nxt    = '0;
      w_long_nxt = 1'b0;
      if (!w_s_nxt || w_rise_nxt) begin
         w_h_nxt = '0;
`ifdef DEBOUNCER_BANK_REPEAT_EN
      end else if (r_h == C_H_WRAP) begin
         w_h_nxt    = C_H_HOLD;
         w_long_nxt = 1'b1;
`else
      end else if (r_h == C_H_HOLD) begin
         w_h_nxt = C_H_HOLD;
`endif
      end else begin
         w_h_nxt    = w_h_inc;
         w_long_nxt = (w_h_inc == C_H_HOLD);
      end
   end

   // State and registered event outputs.
   always_ff @(posedge i_ck or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync <= 1'b0;
         r_xs   <= 1'b0;
         r_s    <= 1'b0;
         r_cnt  <= '0;
         r_h    <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         r_long <= 1'b0;
      end else begin
         r_sync <= i_x;
         r_xs   <= r_sync;
         r_s    <= w_s_nxt;
         r_cnt  <= w_cnt_nxt;
         r_h    <= w_h_nxt;
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
         r_long <= w_long_nxt;
      end
   end

   assign o_evt = '{z: r_s, rise: r_rise, fall: r_fall, long: r_long};

endmodule

// File: rtl/debouncer_bank.sv
// N independent debouncer channels with press, release and long-press pulses.
// Define DEBOUNCER_BANK_REPEAT_EN to make long-press repeat every REPEAT cycles.
module debouncer_bank
   import debouncer_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int DELAY  = DEF_DELAY,
   parameter int HOLD   = DEF_HOLD,
   parameter int REPEAT = DEF_REPEAT
) (
   input  logic         ck,
   input  logic         reset_n,
   input  logic [N-1:0] x,
   output logic [N-1:0] z,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic [N-1:0] long
);

   ch_evt_t w_evt [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_ch
      debouncer_channel #(
         .DELAY  (DELAY),
         .HOLD   (HOLD),
         .REPEAT (REPEAT)
      ) u_ch (
         .i_ck      (ck),
         .i_reset_n (reset_n),
         .i_x       (x[gi]),
         .o_evt     (w_evt[gi])
      );

      assign z[gi]    = w_evt[gi].z;
      assign rise[gi] = w_evt[gi].rise;
      assign fall[gi] = w_evt[gi].fall;
      assign long[gi] = w_evt[gi].long;
   end

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed self-checking bench for debouncer_bank (N=4, DELAY=5, HOLD=20, REPEAT=8).
// Expectations follow DEBOUNCER_BANK_REPEAT_EN when it is defined.
module tb_debouncer_bank;

   localparam int N      = 4;
   localparam int DELAY  = 5;
   localparam int HOLD   = 20;
   localparam int REPEAT = 8;

   logic         ck = 1'b0;
   logic         reset_n;
   logic [N-1:0] x;
   logic [N-1:0] z;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] long;

   int total = 0;
   int bad   = 0;

   debouncer_bank #(
      .N      (N),
      .DELAY  (DELAY),
      .HOLD   (HOLD),
      .REPEAT (REPEAT)
   ) dut (
      .ck      (ck),
      .reset_n (reset_n),
      .x       (x),
      .z       (z),
      .rise    (rise),
      .fall    (fall),
      .long    (long)
   );

   always #10 ck = ~ck;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge ck);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [15:0] obs;
      reset_n = 1'b1;
      x       = 4'b1111;
      #2;
      reset_n = 1'b0;
      step(3);
      obs = {z, rise, fall, long};
      total++;
      if (obs !== 16'h0000) begin
         bad++;
         $display("FAIL reset_hold: got %h want 0000", obs);
      end
      reset_n = 1'b1;
      for (int m = 1; m <= 12; m++) begin
         step(1);
         if (m == 1) x = 4'b0000;
         obs = {z, rise, fall, long};
         total++;
         if (obs !== 16'h0000) begin
            bad++;
            $display("FAIL reset_release m=%0d: got %h want 0000", m, obs);
         end
      end
   endtask

   task automatic test_glitch();
      logic [15:0] obs;
      for (int w = 3; w <= DELAY - 1; w++) begin
         x[0] = 1'b1;
         step(w);
         x[0] = 1'b0;
         for (int m = 1; m <= 12; m++) begin
            step(1);
            obs = {z, rise, fall, long};
            total++;
            if (obs !== 16'h0000) begin
               bad++;
               $display("FAIL glitch w=%0d m=%0d: got %h want 0000", w, m, obs);
            end
         end
      end
   endtask

   task automatic test_clean_press();
      logic [15:0] obs;
      logic [15:0] exp;
      x[1] = 1'b1;
      for (int m = 1; m <= 10; m++) begin
         step(1);
         exp = {(m >= 7) ? 4'b0010 : 4'b0000, (m == 7) ? 4'b0010 : 4'b0000, 8'h00};
         obs = {z, rise, fall, long};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL press m=%0d: got %h want %h", m, obs, exp);
         end
      end
      x[1] = 1'b0;
      for (int m = 1; m <= 12; m++) begin
         step(1);
         exp = {(m < 7) ? 4'b0010 : 4'b0000, 4'b0000, (m == 7) ? 4'b0010 : 4'b0000, 4'b0000};
         obs = {z, rise, fall, long};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL release m=%0d: got %h want %h", m, obs, exp);
         end
      end
   endtask

   task automatic test_bounce();
      logic [15:0] obs;
      logic [15:0] exp;
      x[2] = 1'b1;
      step(2);
      x[2] = 1'b0;
      step(2);
      x[2] = 1'b1;
      for (int m = 1; m <= 10; m++) begin
         step(1);
         exp = {(m >= 7) ? 4'b0100 : 4'b0000, (m == 7) ? 4'b0100 : 4'b0000, 8'h00};
         obs = {z, rise, fall, long};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL bounce m=%0d: got %h want %h", m, obs, exp);
         end
      end
      x[2] = 1'b0;
      step(12);
      total++;
      if (z !== 4'b0000) begin
         bad++;
         $display("FAIL bounce_idle: got z=%b want 0000", z);
      end
   endtask

   task automatic test_long_press();
      logic [15:0] obs;
      logic [15:0] exp;
      logic        exp_long;
      x[3] = 1'b1;
      for (int m = 1; m <= 60; m++) begin
         step(1);
         exp_long = (m == 27);
`ifdef DEBOUNCER_BANK_REPEAT_EN
         exp_long = exp_long || (m == 35) || (m == 43);
`endif
         exp = {(m >= 7 && m <= 46) ? 4'b1000 : 4'b0000,
                (m == 7)  ? 4'b1000 : 4'b0000,
                (m == 47) ? 4'b1000 : 4'b0000,
                exp_long  ? 4'b1000 : 4'b0000};
         obs = {z, rise, fall, long};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL long_press m=%0d: got %h want %h", m, obs, exp);
         end
         if (m == 40) x[3] = 1'b0;
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] obs;
      logic [15:0] exp;
      x = 4'b1111;
      for (int m = 1; m <= 40; m++) begin
         step(1);
         exp = {(m >= 7 && m <= 26) ? 4'b1111 : 4'b0000,
                (m == 7)  ? 4'b1111 : 4'b0000,
                (m == 27) ? 4'b1111 : 4'b0000,
                4'b0000};
         obs = {z, rise, fall, long};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL simultaneous m=%0d: got %h want %h", m, obs, exp);
         end
         if (m == 20) x = 4'b0000;
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] obs;
      logic [15:0] exp;
      x = 4'b1000;
      step(10);
      total++;
      if (z !== 4'b1000) begin
         bad++;
         $display("FAIL reset_mid_setup: got z=%b want 1000", z);
      end
      x[1] = 1'b1;
      step(3);
      reset_n = 1'b0;
      #1;
      obs = {z, rise, fall, long};
      total++;
      if (obs !== 16'h0000) begin
         bad++;
         $display("FAIL reset_mid_async: got %h want 0000", obs);
      end
      step(1);
      obs = {z, rise, fall, long};
      total++;
      if (obs !== 16'h0000) begin
         bad++;
         $display("FAIL reset_mid_edge: got %h want 0000", obs);
      end
      reset_n = 1'b1;
      for (int m = 1; m <= 10; m++) begin
         step(1);
         exp = {(m >= 7) ? 4'b1010 : 4'b0000, (m == 7) ? 4'b1010 : 4'b0000, 8'h00};
         obs = {z, rise, fall, long};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL reset_mid_rerise m=%0d: got %h want %h", m, obs, exp);
         end
      end
      x = 4'b0000;
      step(12);
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_clean_press();
      test_bounce();
      test_long_press();
      test_simultaneous();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
